// File: rtl/brick_storage.sv
// Brick wall status store: alive bits, brick index walker with screen
// coordinates, and a three-state read/delete handshake for the sprite FSM.
module brick_storage #(
    parameter int NUM_COLS = 10,
    parameter int NUM_ROWS = 6,
    parameter int BRICK_W  = 16,
    parameter int BRICK_H  = 5,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 10
) (
    input  logic       clock,
    input  logic       reset_control,
    input  logic       brick_storage_reset,
    input  logic       brick_gen_reset,
    input  logic       brick_gen_enable,
    input  logic       check_status,
    input  logic       delete_brick,
    output logic [5:0] brick_count,
    output logic [7:0] brick_counter_x,
    output logic [6:0] brick_counter_y,
    output logic       got_brick,
    output logic       brick_alive,
    output logic [2:0] brick_colour,
    output logic [5:0] bricks_remaining,
    output logic       all_cleared
);

    localparam int         NB       = NUM_COLS * NUM_ROWS;
    localparam logic [5:0] NB6      = 6'(NB);
    localparam logic [5:0] LAST_COL = 6'(NUM_COLS - 1);
    localparam logic [7:0] X_BASE   = 8'(X_OFFSET);
    localparam logic [6:0] Y_BASE   = 7'(Y_OFFSET);

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t        state_q, state_d;
    logic [NB-1:0] status_q, status_d;
    logic [5:0]    index_q, index_d;
    logic [5:0]    col_q, col_d;
    logic [2:0]    rmod_q, rmod_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [5:0]    addr_q, addr_d;
    logic [2:0]    addr_rmod_q, addr_rmod_d;
    logic [5:0]    remaining_q, remaining_d;
    logic          alive_q, alive_d;
    logic [2:0]    colour_q, colour_d;
    logic          cleared_q, cleared_d;

    logic [63:0]   status_ext;
    logic [63:0]   clr_mask;
    logic          cur_bit;

    function automatic logic [2:0] row_colour(input logic [2:0] r);
        case (r)
            3'd0:    row_colour = 3'b100;
            3'd1:    row_colour = 3'b110;
            3'd2:    row_colour = 3'b010;
            3'd3:    row_colour = 3'b011;
            3'd4:    row_colour = 3'b001;
            3'd5:    row_colour = 3'b101;
            default: row_colour = 3'b000;
        endcase
    endfunction

    // Addresses at or past NB read as dead bricks via zero padding.
    assign status_ext = 64'(status_q);
    assign cur_bit    = status_ext[addr_q];
    assign clr_mask   = 64'd1 << addr_q;

    // Row is tracked modulo 6 alongside col so colour needs no divider.
    always_comb begin
        index_d = index_q;
        col_d   = col_q;
        rmod_d  = rmod_q;
        x_d     = x_q;
        y_d     = y_q;
        if (!brick_gen_reset) begin
            index_d = 6'd0;
            col_d   = 6'd0;
            rmod_d  = 3'd0;
            x_d     = X_BASE;
            y_d     = Y_BASE;
        end else if (brick_gen_enable && (index_q < NB6)) begin
            index_d = index_q + 6'd1;
            if (index_q != NB6 - 6'd1) begin
                if (col_q < LAST_COL) begin
                    col_d = col_q + 6'd1;
                    x_d   = x_q + 8'(BRICK_W);
                end else begin
                    col_d  = 6'd0;
                    x_d    = X_BASE;
                    y_d    = y_q + 7'(BRICK_H);
                    rmod_d = (rmod_q == 3'd5) ? 3'd0 : rmod_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_rmod_d = addr_rmod_q;
        status_d    = status_q;
        remaining_d = remaining_q;
        alive_d     = alive_q;
        colour_d    = colour_q;
        cleared_d   = (remaining_q == 6'd0);
        case (state_q)
            IDLE: begin
                if (check_status) begin
                    state_d     = FETCH;
                    addr_d      = index_q;
                    addr_rmod_d = rmod_q;
                end
            end
            FETCH: begin
                state_d  = VALID;
                alive_d  = cur_bit;
                colour_d = (cur_bit && !delete_brick) ? row_colour(addr_rmod_q) : 3'b000;
                if (delete_brick && cur_bit) begin
                    status_d = status_q & ~clr_mask[NB-1:0];
                    if (remaining_q != 6'd0) begin
                        remaining_d = remaining_q - 6'd1;
                    end
                end
            end
            VALID: begin
                if (!check_status) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!brick_storage_reset) begin
            state_d     = IDLE;
            status_d    = '1;
            remaining_d = NB6;
            cleared_d   = 1'b0;
            alive_d     = 1'b0;
            colour_d    = 3'b000;
        end
    end

    always_ff @(posedge clock or negedge reset_control) begin
        if (!reset_control) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_control) begin
        if (!reset_control) begin
            status_q    <= '1;
            index_q     <= 6'd0;
            col_q       <= 6'd0;
            rmod_q      <= 3'd0;
            x_q         <= X_BASE;
            y_q         <= Y_BASE;
            addr_q      <= 6'd0;
            addr_rmod_q <= 3'd0;
            remaining_q <= NB6;
            alive_q     <= 1'b0;
            colour_q    <= 3'b000;
            cleared_q   <= 1'b0;
        end else begin
            status_q    <= status_d;
            index_q     <= index_d;
            col_q       <= col_d;
            rmod_q      <= rmod_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            addr_rmod_q <= addr_rmod_d;
            remaining_q <= remaining_d;
            alive_q     <= alive_d;
            colour_q    <= colour_d;
            cleared_q   <= cleared_d;
        end
    end

    assign brick_count      = index_q;
    assign brick_counter_x  = x_q;
    assign brick_counter_y  = y_q;
    assign got_brick        = (state_q == VALID);
    assign brick_alive      = alive_q;
    assign brick_colour     = colour_q;
    assign bricks_remaining = remaining_q;
    assign all_cleared      = cleared_q;

endmodule
